// File: rtl/div_unit_iter.sv
// Multi-cycle radix-2 restoring integer divider with valid/ready on both sides.
// Handles signed/unsigned ops, divide-by-zero, flush, and output backpressure; carries an opaque tag.
module div_unit_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic [WIDTH-1:0] out_r,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dbz
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             quo_neg_q, quo_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0] q_res_q, q_res_d;
  logic [WIDTH-1:0] r_res_q, r_res_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic             ge;
  logic             last;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] abs_x;
  logic [WIDTH-1:0] abs_y;

  assign in_ready  = ~flush & ((state_q == StIdle) | ((state_q == StDone) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == StDone);
  assign out_q     = q_res_q;
  assign out_r     = r_res_q;
  assign out_tag   = tag_q;
  assign out_dbz   = dbz_q;

  assign abs_x = (in_signed & in_x[WIDTH-1]) ? -in_x : in_x;
  assign abs_y = (in_signed & in_y[WIDTH-1]) ? -in_y : in_y;

  // Dividend register shifts out its MSB each step and shifts the quotient bit in at the LSB.
  assign rem_sh  = {rem_q, dvd_q[WIDTH-1]};
  assign diff    = rem_sh - {1'b0, div_q};
  assign ge      = ~diff[WIDTH];
  assign rem_nxt = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_nxt = {dvd_q[WIDTH-2:0], ge};
  assign last    = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    div_d     = div_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    q_res_d   = q_res_q;
    r_res_d   = r_res_q;
    tag_d     = tag_q;
    dbz_d     = dbz_q;

    if (flush) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StCalc: begin
          rem_d = rem_nxt;
          dvd_d = quo_nxt;
          cnt_d = cnt_q + CNT_W'(1);
          if (last) begin
            state_d = StDone;
            q_res_d = quo_neg_q ? -quo_nxt : quo_nxt;
            r_res_d = rem_neg_q ? -rem_nxt : rem_nxt;
            dbz_d   = 1'b0;
          end
        end
        StDone: begin
          if (out_ready) state_d = StIdle;
        end
        StIdle: ;
        default: state_d = StIdle;
      endcase

      // An accept in DONE overrides the return to IDLE, so back-to-back ops have no bubble.
      if (accept) begin
        dvd_d     = abs_x;
        div_d     = abs_y;
        rem_d     = '0;
        cnt_d     = '0;
        quo_neg_d = in_signed & (in_x[WIDTH-1] ^ in_y[WIDTH-1]);
        rem_neg_d = in_signed & in_x[WIDTH-1];
        tag_d     = in_tag;
        if (in_y == '0) begin
          state_d = StDone;
          q_res_d = '1;
          r_res_d = in_x;
          dbz_d   = 1'b1;
        end else begin
          state_d = StCalc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      div_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      q_res_q   <= '0;
      r_res_q   <= '0;
      tag_q     <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      div_q     <= div_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      q_res_q   <= q_res_d;
      r_res_q   <= r_res_d;
      tag_q     <= tag_d;
      dbz_q     <= dbz_d;
    end
  end

endmodule

// File: tb/tb_div_unit_iter.sv
// Self-checking bench for div_unit_iter: a 32-bit and an 8-bit instance driven by directed steps,
// with expected results queued at issue and compared when each result appears.
module tb_div_unit_iter;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_in_signed, a_out_valid, a_out_ready, a_out_dbz;
  logic [31:0] a_in_x, a_in_y, a_out_q, a_out_r;
  logic [4:0]  a_in_tag, a_out_tag;

  logic        b_in_valid, b_in_ready, b_in_signed, b_out_valid, b_out_ready, b_out_dbz;
  logic [7:0]  b_in_x, b_in_y, b_out_q, b_out_r;
  logic [4:0]  b_in_tag, b_out_tag;

  div_unit_iter #(.WIDTH(32), .CNT_W(6), .TAG_W(5)) dut_a (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_signed(a_in_signed),
    .in_x(a_in_x), .in_y(a_in_y), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_q(a_out_q), .out_r(a_out_r), .out_tag(a_out_tag), .out_dbz(a_out_dbz)
  );

  div_unit_iter #(.WIDTH(8), .CNT_W(4), .TAG_W(5)) dut_b (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_signed(b_in_signed),
    .in_x(b_in_x), .in_y(b_in_y), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_q(b_out_q), .out_r(b_out_r), .out_tag(b_out_tag), .out_dbz(b_out_dbz)
  );

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic [4:0]  tag;
    logic        dbz;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t last_exp;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] q, input logic [31:0] r, input logic [4:0] tag,
                              input logic dbz);
    exp_t e;
    e.q = q; e.r = r; e.tag = tag; e.dbz = dbz;
    return e;
  endfunction

  // Reference quotient/remainder via 64-bit arithmetic, so MIN/-1 cannot overflow.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input bit sgn,
                                 input int w, input logic [4:0] tag);
    logic [63:0] m, qq, rr;
    longint      sx, sy;
    exp_t        e;
    m = (64'd1 << w) - 64'd1;
    e.tag = tag;
    if (y == 32'd0) begin
      e.q = m[31:0]; e.r = x; e.dbz = 1'b1;
    end else begin
      sx = $signed({32'd0, x});
      sy = $signed({32'd0, y});
      if (sgn && x[w-1]) sx = sx - $signed(64'd1 << w);
      if (sgn && y[w-1]) sy = sy - $signed(64'd1 << w);
      qq = sx / sy;
      rr = sx % sy;
      e.q = qq[31:0] & m[31:0]; e.r = rr[31:0] & m[31:0]; e.dbz = 1'b0;
    end
    return e;
  endfunction

  function automatic logic o_valid(input bit b);  return b ? b_out_valid : a_out_valid; endfunction
  function automatic logic o_ready(input bit b);  return b ? b_in_ready : a_in_ready;   endfunction
  function automatic logic o_dbz(input bit b);    return b ? b_out_dbz : a_out_dbz;     endfunction
  function automatic logic [31:0] o_q(input bit b);   return b ? {24'd0, b_out_q} : a_out_q; endfunction
  function automatic logic [31:0] o_r(input bit b);   return b ? {24'd0, b_out_r} : a_out_r; endfunction
  function automatic logic [31:0] o_tag(input bit b); return {27'd0, (b ? b_out_tag : a_out_tag)}; endfunction

  task automatic chk_out(input bit b, input string name, input exp_t e);
    chk({name, "_q"}, o_q(b), e.q);
    chk({name, "_r"}, o_r(b), e.r);
    chk({name, "_tag"}, o_tag(b), {27'd0, e.tag});
    chk({name, "_dbz"}, {31'd0, o_dbz(b)}, {31'd0, e.dbz});
  endtask

  // Presents an op away from the clock edge and queues its expected result.
  task automatic drive(input bit b, input logic [31:0] x, input logic [31:0] y, input bit sgn,
                       input logic [4:0] tag, input exp_t e);
    if (b) begin
      b_in_valid = 1'b1; b_in_x = x[7:0]; b_in_y = y[7:0]; b_in_signed = sgn; b_in_tag = tag;
      sb_b.push_back(e);
    end else begin
      a_in_valid = 1'b1; a_in_x = x; a_in_y = y; a_in_signed = sgn; a_in_tag = tag;
      sb_a.push_back(e);
    end
    #1;
    chk("in_ready_at_issue", {31'd0, o_ready(b)}, 32'd1);
  endtask

  // Lets the accept edge happen, then counts edges until out_valid and compares the result.
  task automatic wait_result(input bit b, input int exp_lat, input string name);
    int   lat;
    bit   rdy_seen;
    exp_t e;
    rdy_seen = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (b) begin
      b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_x = 8'($urandom); b_in_y = 8'($urandom);
    end else begin
      a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_x = $urandom; a_in_y = $urandom;
    end
    #1;
    lat = 1;
    while (!o_valid(b) && lat < 200) begin
      if (o_ready(b)) rdy_seen = 1'b1;
      @(negedge clk);
      #1;
      lat++;
    end
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({name, "_ready_in_calc"}, {31'd0, rdy_seen}, 32'd0);
    chk({name, "_sb_nonempty"}, {31'd0, (b ? sb_b.size() != 0 : sb_a.size() != 0)}, 32'd1);
    if (b ? sb_b.size() != 0 : sb_a.size() != 0) begin
      e = b ? sb_b.pop_front() : sb_a.pop_front();
      last_exp = e;
      chk_out(b, name, e);
    end
  endtask

  task automatic consume(input bit b);
    if (b) b_out_ready = 1'b1; else a_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (b) b_out_ready = 1'b0; else a_out_ready = 1'b0;
    #1;
    chk("valid_after_consume", {31'd0, o_valid(b)}, 32'd0);
    chk("ready_after_consume", {31'd0, o_ready(b)}, 32'd1);
  endtask

  task automatic run(input bit b, input logic [31:0] x, input logic [31:0] y, input bit sgn,
                     input logic [4:0] tag, input exp_t e, input string name);
    drive(b, x, y, sgn, tag, e);
    wait_result(b, (y == 32'd0) ? 1 : (b ? 9 : 33), name);
    consume(b);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rx, ry;
    bit          rs, rb;
    a_in_valid = 0; a_in_signed = 0; a_in_x = 0; a_in_y = 0; a_in_tag = 0; a_out_ready = 0;
    b_in_valid = 0; b_in_signed = 0; b_in_x = 0; b_in_y = 0; b_in_tag = 0; b_out_ready = 0;

    repeat (2) @(negedge clk);
    #1;
    chk_out(1'b0, "reset", mk(32'd0, 32'd0, 5'd0, 1'b0));
    chk("reset_valid", {31'd0, a_out_valid}, 32'd0);
    chk("reset_ready", {31'd0, a_in_ready}, 32'd1);
    resetn = 1'b1;
    @(negedge clk);

    run(0, 32'd100, 32'd7, 0, 5'h01, mk(32'd14, 32'd2, 5'h01, 0), "t1_100_7");
    run(0, 32'hFFFFFFF9, 32'd2, 1, 5'h02, mk(32'hFFFFFFFD, 32'hFFFFFFFF, 5'h02, 0), "t2_m7_2");
    run(0, 32'd7, 32'hFFFFFFFE, 1, 5'h03, mk(32'hFFFFFFFD, 32'd1, 5'h03, 0), "t2_7_m2");
    run(0, 32'hFFFFFFF9, 32'd2, 0, 5'h04, mk(32'h7FFFFFFC, 32'd1, 5'h04, 0), "t2_uns");
    run(0, 32'h80000000, 32'hFFFFFFFF, 1, 5'h05, mk(32'h80000000, 32'd0, 5'h05, 0), "t3_ovf_s");
    run(0, 32'h80000000, 32'hFFFFFFFF, 0, 5'h06, mk(32'd0, 32'h80000000, 5'h06, 0), "t3_ovf_u");
    run(0, 32'd5, 32'd0, 0, 5'h13, mk(32'hFFFFFFFF, 32'd5, 5'h13, 1), "t4_dbz");

    // Backpressure: hold result, then consume and accept the next op on the same edge.
    drive(0, 32'd1000, 32'd7, 0, 5'h07, mk(32'd142, 32'd6, 5'h07, 0));
    wait_result(0, 33, "t5_hold");
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("t5_hold_valid", {31'd0, a_out_valid}, 32'd1);
      chk_out(0, "t5_hold", last_exp);
    end
    a_out_ready = 1'b1;
    drive(0, 32'd9, 32'd3, 0, 5'h08, mk(32'd3, 32'd0, 5'h08, 0));
    wait_result(0, 33, "t5_nobubble");
    consume(0);

    // Flush at CALC cycle 10, with a competing op presented during the flush cycle.
    a_in_valid = 1'b1; a_in_x = 32'd50; a_in_y = 32'd5; a_in_signed = 0; a_in_tag = 5'h09;
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1; a_in_valid = 1'b1; a_in_x = 32'd60; a_in_y = 32'd6;
    #1;
    chk("t6_ready_in_flush", {31'd0, a_in_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    a_in_valid = 1'b0;
    #1;
    chk("t6_valid_after_flush", {31'd0, a_out_valid}, 32'd0);
    chk("t6_ready_after_flush", {31'd0, a_in_ready}, 32'd1);
    drive(0, 32'd77, 32'd10, 0, 5'h0A, mk(32'd7, 32'd7, 5'h0A, 0));
    wait_result(0, 33, "t6_after_flush");
    consume(0);

    // Flush discards an unconsumed result even with out_ready high.
    drive(0, 32'd20, 32'd4, 0, 5'h0B, mk(32'd5, 32'd0, 5'h0B, 0));
    wait_result(0, 33, "t6_done");
    flush = 1'b1; a_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; a_out_ready = 1'b0;
    #1;
    chk("t6_done_flushed_valid", {31'd0, a_out_valid}, 32'd0);
    chk("t6_done_flushed_ready", {31'd0, a_in_ready}, 32'd1);

    // Asynchronous reset mid-CALC clears outputs immediately.
    a_in_valid = 1'b1; a_in_x = 32'd200; a_in_y = 32'd9; a_in_signed = 0; a_in_tag = 5'h0C;
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk_out(0, "t6_reset", mk(32'd0, 32'd0, 5'd0, 0));
    chk("t6_reset_valid", {31'd0, a_out_valid}, 32'd0);
    chk("t6_reset_ready", {31'd0, a_in_ready}, 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run(0, 32'd100, 32'd7, 0, 5'h0D, mk(32'd14, 32'd2, 5'h0D, 0), "t6_post_reset");

    run(1, 32'd100, 32'd7, 0, 5'h11, mk(32'd14, 32'd2, 5'h11, 0), "w8_100_7");
    run(1, 32'hF9, 32'd2, 1, 5'h12, mk(32'hFD, 32'hFF, 5'h12, 0), "w8_m7_2");
    run(1, 32'd7, 32'hFE, 1, 5'h14, mk(32'hFD, 32'd1, 5'h14, 0), "w8_7_m2");
    run(1, 32'hF9, 32'd2, 0, 5'h15, mk(32'h7C, 32'd1, 5'h15, 0), "w8_uns");
    run(1, 32'h80, 32'hFF, 1, 5'h16, mk(32'h80, 32'd0, 5'h16, 0), "w8_ovf_s");
    run(1, 32'h80, 32'hFF, 0, 5'h17, mk(32'd0, 32'h80, 5'h17, 0), "w8_ovf_u");
    run(1, 32'd5, 32'd0, 0, 5'h18, mk(32'hFF, 32'd5, 5'h18, 1), "w8_dbz");

    for (int i = 0; i < 16; i++) begin
      rb = i[0];
      rs = i[1];
      rx = $urandom;
      ry = (i % 4 == 3) ? ($urandom & 32'hFF) : $urandom;
      if (i == 6) ry = 32'd0;
      if (rb) begin
        rx = rx & 32'hFF;
        ry = ry & 32'hFF;
      end
      run(rb, rx, ry, rs, 5'(i), model(rx, ry, rs, rb ? 8 : 32, 5'(i)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
